alu_sequencer: RTL
==================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter: REG_INIT, 8'h00, value loaded into every register-file entry on reset.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 instr_valid  input  1  instruction offered this cycle.
REQ-005 instr  input  8  [7:5] op, [4:3] rd, [2:1] rs, [0] use_imm.
REQ-006 imm  input  8  immediate operand, sampled with instr.
REQ-007 instr_ready  output  1  sequencer can accept an instruction.
REQ-008 alu_operand1  output  8  registered ALU first operand.
REQ-009 alu_operand2  output  8  registered ALU second operand.
REQ-010 alu_operation  output  4  registered ALU opcode, {1'b0, op}.
REQ-011 alu_result  input  8  combinational ALU result.
REQ-012 alu_carry_out  input  1  ALU add carry.
REQ-013 done  output  1  one-cycle pulse, instruction retired.
REQ-014 wb_data  output  8  value written to rd; valid while done=1.
REQ-015 zero_flag, carry_flag, err_flag  output  1 each  status flags.
REQ-016 dbg_sel  input  2 / dbg_data  output  8  combinational read of register dbg_sel.

Function
REQ-017 Register file: four 8-bit registers R0-R3, written only by this block.
REQ-018 States IDLE, EXEC, WB; IDLE->EXEC on handshake, EXEC->WB unconditionally, WB->IDLE unconditionally.
REQ-019 instr_ready = 1 exactly in IDLE; handshake = instr_valid && instr_ready; instr_valid ignored outside IDLE.
REQ-020 On handshake edge: alu_operand1 <= R[rd]; alu_operand2 <= use_imm ? imm : R[rs]; alu_operation <= {1'b0, op}; instr fields latched.
REQ-021 ALU outputs hold stable from handshake edge until the next handshake.
REQ-022 EXEC->WB edge, op 000-110: R[rd] <= alu_result; wb_data <= alu_result; done <= 1.
REQ-023 op 111 (MOV): ALU bypassed; R[rd] <= alu_operand2; wb_data <= alu_operand2; alu_operation still driven 4'b0111.
REQ-024 zero_flag <= (written value == 0) on every writeback.
REQ-025 carry_flag <= alu_carry_out on op 000 only; held on all other ops.
REQ-026 done high exactly during WB (one cycle); earliest retirement: done high in the second cycle after handshake edge; throughput one instruction per 3 cycles.
REQ-027 Operands read at handshake, so rd==rs and back-to-back dependent instructions need no forwarding.
REQ-028 Results truncated to 8 bits (MUL low byte); no saturation.
REQ-029 err_flag sticky once set; cleared only by reset.
REQ-030 dbg_data reflects register contents after the write edge, combinational on dbg_sel.

Reset
REQ-031 rst_n low asynchronously forces: state IDLE, R0-R3 = REG_INIT, alu_operand1/2 = 0, alu_operation = 0, wb_data = 0, done = 0, all flags 0.
REQ-032 Reset during EXEC or WB abandons the instruction: no register write, no done pulse.
REQ-033 instr_ready = 1 in the first cycle after rst_n deasserts.

Configuration
REQ-034 Macro ALU_SEQ_DIVZERO_TRAP_EN.
REQ-035 Defined: op 011 with alu_operand2 == 0 -> no register write, zero/carry held, err_flag <= 1, done still pulses with wb_data = 8'hFF.
REQ-036 Undefined: op 011 with zero divisor handled as any ALU op (REQ-022); err_flag tied 0.

Verification
REQ-037 Reset, then MOV R1,#8'h05 (use_imm) -> done in cycle 2 after handshake, wb_data=8'h05, dbg_sel=1 reads 8'h05, zero_flag=0.
REQ-038 R1=8'hF0, R2=8'h20, ADD R1,R2 -> alu_operand1=F0, alu_operand2=20, alu_operation=0000, R1=8'h10, carry_flag=1, zero_flag=0.
REQ-039 R3=8'hAA, XOR R3,R3 -> R3=8'h00, zero_flag=1, carry_flag unchanged.
REQ-040 instr_valid held high with three back-to-back instructions -> instr_ready pattern 1,0,0 repeating; exactly three done pulses.
REQ-041 R0=8'h09, DIV R0,#0 with macro defined -> R0 stays 8'h09, err_flag=1, wb_data=FF; undefined -> R0=alu_result, err_flag=0.
REQ-042 Assert rst_n low during EXEC of MOV R2,#7F -> no done, R2=REG_INIT, instr_ready=1 after release.

Source files
------------

// File: rtl/alu_sequencer.sv
// alu_sequencer: three-state instruction sequencer (IDLE -> EXEC -> WB) driving an
// external combinational ALU and owning a 4 x 8-bit register file.
// Optional feature macro: ALU_SEQ_DIVZERO_TRAP_EN (op 011 with a zero divisor retires
// without a register write and sets the sticky err_flag).
module alu_sequencer #(
    parameter logic [7:0] REG_INIT = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       instr_valid,
    input  logic [7:0] instr,
    input  logic [7:0] imm,
    output logic       instr_ready,
    output logic [7:0] alu_operand1,
    output logic [7:0] alu_operand2,
    output logic [3:0] alu_operation,
    input  logic [7:0] alu_result,
    input  logic       alu_carry_out,
    output logic       done,
    output logic [7:0] wb_data,
    output logic       zero_flag,
    output logic       carry_flag,
    output logic       err_flag,
    input  logic [1:0] dbg_sel,
    output logic [7:0] dbg_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    state_t     r_state;
    logic [7:0] r_regs [4];
    logic [1:0] r_rd;

    logic [7:0] w_wb_value;
    logic       w_div_trap;

    // Writeback value selection: MOV bypasses the ALU and forwards operand 2.
    always_comb begin
        w_wb_value = (alu_operation[2:0] == 3'b111) ? alu_operand2 : alu_result;
`ifdef ALU_SEQ_DIVZERO_TRAP_EN
        w_div_trap = (alu_operation[2:0] == 3'b011) && (alu_operand2 == 8'h00);
`else
        w_div_trap = 1'b0;
`endif
    end

    assign instr_ready = (r_state == IDLE);
    assign dbg_data    = r_regs[dbg_sel];

`ifndef ALU_SEQ_DIVZERO_TRAP_EN
    assign err_flag = 1'b0;
`endif

    // Sequencer FSM with registered ALU operands, writeback, flags and register file.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_rd          <= 2'd0;
            alu_operand1  <= 8'h00;
            alu_operand2  <= 8'h00;
            alu_operation <= 4'h0;
            wb_data       <= 8'h00;
            done          <= 1'b0;
            zero_flag     <= 1'b0;
            carry_flag    <= 1'b0;
`ifdef ALU_SEQ_DIVZERO_TRAP_EN
            err_flag      <= 1'b0;
`endif
            for (int i = 0; i < 4; i++) begin
                r_regs[i] <= REG_INIT;
            end
        end else begin
            done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    // Operands are captured here, so dependent instructions need no forwarding.
                    if (instr_valid) begin
                        alu_operand1  <= r_regs[instr[4:3]];
                        alu_operand2  <= instr[0] ? imm : r_regs[instr[2:1]];
                        alu_operation <= {1'b0, instr[7:5]};
                        r_rd          <= instr[4:3];
                        r_state       <= EXEC;
                    end
                end
                EXEC: begin
                    done    <= 1'b1;
                    r_state <= WB;
                    if (w_div_trap) begin
                        wb_data  <= 8'hFF;
`ifdef ALU_SEQ_DIVZERO_TRAP_EN
                        err_flag <= 1'b1;
`endif
                    end else begin
                        r_regs[r_rd] <= w_wb_value;
                        wb_data      <= w_wb_value;
                        zero_flag    <= (w_wb_value == 8'h00);
                        if (alu_operation[2:0] == 3'b000) begin
                            carry_flag <= alu_carry_out;
                        end
                    end
                end
                WB: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
